control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_defs_pkg.sv | 79 +++++++
 rtl/op_decode.sv | 34 +++
 rtl/control_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode encodings, control-unit states,
// instruction classes and the control-strobe bundle.
package cpu_defs;

  typedef enum logic [4:0] {
    OP_LD   = 5'd0,
    OP_LDI  = 5'd1,
    OP_ST   = 5'd2,
    OP_ADD  = 5'd3,
    OP_SUB  = 5'd4,
    OP_AND  = 5'd9,
    OP_OR   = 5'd10,
    OP_ADDI = 5'd11,
    OP_ANDI = 5'd12,
    OP_ORI  = 5'd13,
    OP_BR   = 5'd18,
    OP_JR   = 5'd19,
    OP_IN   = 5'd21,
    OP_OUT  = 5'd22,
    OP_MFHI = 5'd23,
    OP_MFLO = 5'd24,
    OP_NOP  = 5'd25,
    OP_HALT = 5'd26
  } opcode_e;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_LD, C_LDI, C_ST, C_ALU,
    C_IMM, C_BR, C_JR, C_MFHI, C_MFLO,
    C_IN, C_OUT, C_HALT
  } cls_e;

  typedef struct packed {
    logic pcout;
    logic pcin;
    logic incpc;
    logic marin;
    logic mdrin;
    logic mdrout;
    logic read;
    logic ramin;
    logic irin;
    logic yin;
    logic zlowin;
    logic zlowout;
    logic cout;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic baout;
    logic conin;
    logic hiout;
    logic loout;
    logic inportout;
    logic outportin;
    logic run;
  } ctrl_t;

  // Final execute state of each instruction class.
  function automatic state_e last_state(cls_e c);
    state_e s;
    unique case (c)
      C_LD, C_ST:           s = S_T7;
      C_BR:                 s = S_T6;
      C_LDI, C_ALU, C_IMM:  s = S_T5;
      C_JR, C_MFHI, C_MFLO,
      C_IN, C_OUT:          s = S_T3;
      default:              s = S_T2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/op_decode.sv
// Opcode to instruction-class decode selecting the T3 path.
// Ports: i_opcode (IR[31:27]) in, o_cls instruction class out.
module op_decode
  import cpu_defs::*;
(
  input  logic [4:0] i_opcode,
  output cls_e       o_cls
);

  always_comb begin
    o_cls = C_NONE;
    case (i_opcode)
      OP_LD:   o_cls = C_LD;
      OP_LDI:  o_cls = C_LDI;
      OP_ST:   o_cls = C_ST;
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR:   o_cls = C_ALU;
      OP_ADDI,
      OP_ANDI,
      OP_ORI:  o_cls = C_IMM;
      OP_BR:   o_cls = C_BR;
      OP_JR:   o_cls = C_JR;
      OP_IN:   o_cls = C_IN;
      OP_OUT:  o_cls = C_OUT;
      OP_MFHI: o_cls = C_MFHI;
      OP_MFLO: o_cls = C_MFLO;
      OP_HALT: o_cls = C_HALT;
      default: o_cls = C_NONE;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0..T2, per-class T3..T7, HALT.
// Ports: i_clock, i_clear (async low), i_opcode, i_con_ff, i_stop
// in; o_* register/memory/bus strobes and o_run out.
module control_sequencer
  import cpu_defs::*;
(
  input  logic       i_clock,
  input  logic       i_clear,
  input  logic [4:0] i_opcode,
  input  logic       i_con_ff,
  input  logic       i_stop,
  output logic       o_pcout,
  output logic       o_pcin,
  output logic       o_incpc,
  output logic       o_marin,
  output logic       o_mdrin,
  output logic       o_mdrout,
  output logic       o_read,
  output logic       o_ramin,
  output logic       o_irin,
  output logic       o_yin,
  output logic       o_zlowin,
  output logic       o_zlowout,
  output logic       o_cout,
  output logic       o_gra,
  output logic       o_grb,
  output logic       o_grc,
  output logic       o_rin,
  output logic       o_rout,
  output logic       o_baout,
  output logic       o_conin,
  output logic       o_hiout,
  output logic       o_loout,
  output logic       o_inportout,
  output logic       o_outportin,
  output logic       o_run
);

  state_e r_state;
  state_e w_next;
  cls_e   r_cls;
  cls_e   w_cls;
  cls_e   w_cur;
  ctrl_t  w_c;

  op_decode u_dec (
    .i_opcode (i_opcode),
    .o_cls    (w_cls)
  );

  // The class is captured at T2 exit, so later opcode changes are ignored.
  assign w_cur = (r_state == S_T2) ? w_cls : r_cls;

  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_state <= S_RESET;
      r_cls   <= C_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == S_T2) r_cls <= w_cls;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RESET: w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      default: begin
        if (r_state == S_T2 && w_cls == C_HALT)
          w_next = S_HALT;
        else if (r_state == last_state(w_cur))
          w_next = i_stop ? S_HALT : S_T0;
        else
          w_next = state_e'(r_state + 4'd1);
      end
    endcase
  end

  always_comb begin
    w_c = '0;
    w_c.run = (r_state != S_RESET) && (r_state != S_HALT);
    unique case (r_state)
      S_T0: begin
        w_c.pcout = 1'b1; w_c.marin = 1'b1;
        w_c.incpc = 1'b1; w_c.zlowin = 1'b1;
      end
      S_T1: begin
        w_c.zlowout = 1'b1; w_c.pcin = 1'b1;
        w_c.read = 1'b1; w_c.mdrin = 1'b1;
      end
      S_T2: begin
        w_c.mdrout = 1'b1; w_c.irin = 1'b1;
      end
      S_T3: begin
        case (r_cls)
          C_LD, C_LDI, C_ST: begin
            w_c.grb = 1'b1; w_c.baout = 1'b1; w_c.yin = 1'b1;
          end
          C_ALU, C_IMM: begin
            w_c.grb = 1'b1; w_c.rout = 1'b1; w_c.yin = 1'b1;
          end
          C_BR: begin
            w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.conin = 1'b1;
          end
          C_JR: begin
            w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.pcin = 1'b1;
          end
          C_MFHI: begin
            w_c.gra = 1'b1; w_c.rin = 1'b1; w_c.hiout = 1'b1;
          end
          C_MFLO: begin
            w_c.gra = 1'b1; w_c.rin = 1'b1; w_c.loout = 1'b1;
          end
          C_IN: begin
            w_c.gra = 1'b1; w_c.rin = 1'b1; w_c.inportout = 1'b1;
          end
          C_OUT: begin
            w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.outportin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (r_cls)
          C_LD, C_LDI, C_ST, C_IMM: begin
            w_c.cout = 1'b1; w_c.zlowin = 1'b1;
          end
          C_ALU: begin
            w_c.grc = 1'b1; w_c.rout = 1'b1; w_c.zlowin = 1'b1;
          end
          C_BR: begin
            w_c.pcout = 1'b1; w_c.yin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (r_cls)
          C_LD, C_ST: begin
            w_c.zlowout = 1'b1; w_c.marin = 1'b1;
          end
          C_LDI, C_ALU, C_IMM: begin
            w_c.zlowout = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1;
          end
          C_BR: begin
            w_c.cout = 1'b1; w_c.zlowin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (r_cls)
          C_LD: begin
            w_c.read = 1'b1; w_c.mdrin = 1'b1;
          end
          C_ST: begin
            w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.mdrin = 1'b1;
          end
          // Branch target is loaded only when the condition holds.
          C_BR: begin
            w_c.zlowout = i_con_ff; w_c.pcin = i_con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (r_cls)
          C_LD: begin
            w_c.mdrout = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1;
          end
          C_ST: w_c.ramin = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign o_pcout     = w_c.pcout;
  assign o_pcin      = w_c.pcin;
  assign o_incpc     = w_c.incpc;
  assign o_marin     = w_c.marin;
  assign o_mdrin     = w_c.mdrin;
  assign o_mdrout    = w_c.mdrout;
  assign o_read      = w_c.read;
  assign o_ramin     = w_c.ramin;
  assign o_irin      = w_c.irin;
  assign o_yin       = w_c.yin;
  assign o_zlowin    = w_c.zlowin;
  assign o_zlowout   = w_c.zlowout;
  assign o_cout      = w_c.cout;
  assign o_gra       = w_c.gra;
  assign o_grb       = w_c.grb;
  assign o_grc       = w_c.grc;
  assign o_rin       = w_c.rin;
  assign o_rout      = w_c.rout;
  assign o_baout     = w_c.baout;
  assign o_conin     = w_c.conin;
  assign o_hiout     = w_c.hiout;
  assign o_loout     = w_c.loout;
  assign o_inportout = w_c.inportout;
  assign o_outportin = w_c.outportin;
  assign o_run       = w_c.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-opcode strobe tables,
// stop/clear corner sequences and a full opcode sweep.
module tb_control_sequencer;

  localparam logic [24:0] PCOUT   = 25'd1 << 0;
  localparam logic [24:0] PCIN    = 25'd1 << 1;
  localparam logic [24:0] INCPC   = 25'd1 << 2;
  localparam logic [24:0] MARIN   = 25'd1 << 3;
  localparam logic [24:0] MDRIN   = 25'd1 << 4;
  localparam logic [24:0] MDROUT  = 25'd1 << 5;
  localparam logic [24:0] READ    = 25'd1 << 6;
  localparam logic [24:0] RAMIN   = 25'd1 << 7;
  localparam logic [24:0] IRIN    = 25'd1 << 8;
  localparam logic [24:0] YIN     = 25'd1 << 9;
  localparam logic [24:0] ZLOWIN  = 25'd1 << 10;
  localparam logic [24:0] ZLOWOUT = 25'd1 << 11;
  localparam logic [24:0] COUT    = 25'd1 << 12;
  localparam logic [24:0] GRA     = 25'd1 << 13;
  localparam logic [24:0] GRB     = 25'd1 << 14;
  localparam logic [24:0] GRC     = 25'd1 << 15;
  localparam logic [24:0] RIN     = 25'd1 << 16;
  localparam logic [24:0] ROUT    = 25'd1 << 17;
  localparam logic [24:0] BAOUT   = 25'd1 << 18;
  localparam logic [24:0] CONIN   = 25'd1 << 19;
  localparam logic [24:0] HIOUT   = 25'd1 << 20;
  localparam logic [24:0] LOOUT   = 25'd1 << 21;
  localparam logic [24:0] INPOUT  = 25'd1 << 22;
  localparam logic [24:0] OUTPIN  = 25'd1 << 23;
  localparam logic [24:0] RUN     = 25'd1 << 24;

  localparam logic [24:0] F0 = PCOUT | MARIN | INCPC | ZLOWIN | RUN;
  localparam logic [24:0] F1 = ZLOWOUT | PCIN | READ | MDRIN | RUN;
  localparam logic [24:0] F2 = MDROUT | IRIN | RUN;
  localparam logic [24:0] DRV = PCOUT | ZLOWOUT | MDROUT | ROUT |
                                COUT | HIOUT | LOOUT | INPOUT;

  typedef struct packed {
    logic [4:0]        op;
    logic              con;
    logic [3:0]        len;
    logic              halts;
    logic [7:0][24:0]  exp;
  } vec_t;

  logic       clk;
  logic       clear;
  logic [4:0] opcode;
  logic       con_ff;
  logic       stop;
  logic o_pcout, o_pcin, o_incpc, o_marin, o_mdrin, o_mdrout;
  logic o_read, o_ramin, o_irin, o_yin, o_zlowin, o_zlowout;
  logic o_cout, o_gra, o_grb, o_grc, o_rin, o_rout, o_baout;
  logic o_conin, o_hiout, o_loout, o_inportout, o_outportin, o_run;
  logic [24:0] act;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  control_sequencer dut (
    .i_clock     (clk),
    .i_clear     (clear),
    .i_opcode    (opcode),
    .i_con_ff    (con_ff),
    .i_stop      (stop),
    .o_pcout     (o_pcout),
    .o_pcin      (o_pcin),
    .o_incpc     (o_incpc),
    .o_marin     (o_marin),
    .o_mdrin     (o_mdrin),
    .o_mdrout    (o_mdrout),
    .o_read      (o_read),
    .o_ramin     (o_ramin),
    .o_irin      (o_irin),
    .o_yin       (o_yin),
    .o_zlowin    (o_zlowin),
    .o_zlowout   (o_zlowout),
    .o_cout      (o_cout),
    .o_gra       (o_gra),
    .o_grb       (o_grb),
    .o_grc       (o_grc),
    .o_rin       (o_rin),
    .o_rout      (o_rout),
    .o_baout     (o_baout),
    .o_conin     (o_conin),
    .o_hiout     (o_hiout),
    .o_loout     (o_loout),
    .o_inportout (o_inportout),
    .o_outportin (o_outportin),
    .o_run       (o_run)
  );

  assign act = {o_run, o_outportin, o_inportout, o_loout, o_hiout,
                o_conin, o_baout, o_rout, o_rin, o_grc, o_grb, o_gra,
                o_cout, o_zlowout, o_zlowin, o_yin, o_irin, o_ramin,
                o_read, o_mdrout, o_mdrin, o_marin, o_incpc, o_pcin,
                o_pcout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] op, input logic con,
                              input int len, input logic halts,
                              input logic [24:0] e3, input logic [24:0] e4,
                              input logic [24:0] e5, input logic [24:0] e6,
                              input logic [24:0] e7);
    vec_t v;
    logic [24:0] t [8];
    v = '0;
    v.op = op; v.con = con; v.len = 4'(len); v.halts = halts;
    t[0] = F0; t[1] = F1; t[2] = F2;
    t[3] = e3; t[4] = e4; t[5] = e5; t[6] = e6; t[7] = e7;
    for (int k = 0; k < len; k++) v.exp[k] = t[k] | RUN;
    return v;
  endfunction

  function automatic int exp_lat(input logic [4:0] op);
    case (op)
      5'd0, 5'd2: return 8;
      5'd1, 5'd3, 5'd4, 5'd9, 5'd10,
      5'd11, 5'd12, 5'd13: return 6;
      5'd18: return 7;
      5'd19, 5'd21, 5'd22, 5'd23, 5'd24: return 4;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
    checks++;
    if ($countones(act & DRV) > 1) begin
      errors++;
      $display("FAIL %s bus: drivers %h want at most one",
               name, act & DRV);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [4:0] op, input logic con);
    clear = 1'b0;
    @(posedge clk);
    #1;
    opcode = op;
    con_ff = con;
    stop = 1'b0;
    clear = 1'b1;
  endtask

  initial begin
    logic [24:0] ld3, ld4, alu3, imm4, tail;
    int n;
    bit done;
    clear = 1'b0; opcode = 5'd0; con_ff = 1'b0; stop = 1'b0;
    #3;
    chk("reset", 25'd0);

    ld3  = GRB | BAOUT | YIN;
    ld4  = COUT | ZLOWIN;
    alu3 = GRB | ROUT | YIN;
    imm4 = COUT | ZLOWIN;
    tail = ZLOWOUT | GRA | RIN;
    tbl.push_back(mk(5'd0, 0, 8, 0, ld3, ld4, ZLOWOUT | MARIN,
                     READ | MDRIN, MDROUT | GRA | RIN));
    tbl.push_back(mk(5'd1, 0, 6, 0, ld3, ld4, tail, 0, 0));
    tbl.push_back(mk(5'd2, 0, 8, 0, ld3, ld4, ZLOWOUT | MARIN,
                     GRA | ROUT | MDRIN, RAMIN));
    tbl.push_back(mk(5'd3, 0, 6, 0, alu3, GRC | ROUT | ZLOWIN, tail, 0, 0));
    tbl.push_back(mk(5'd4, 0, 6, 0, alu3, GRC | ROUT | ZLOWIN, tail, 0, 0));
    tbl.push_back(mk(5'd9, 0, 6, 0, alu3, GRC | ROUT | ZLOWIN, tail, 0, 0));
    tbl.push_back(mk(5'd10, 0, 6, 0, alu3, GRC | ROUT | ZLOWIN, tail, 0, 0));
    tbl.push_back(mk(5'd11, 0, 6, 0, alu3, imm4, tail, 0, 0));
    tbl.push_back(mk(5'd12, 0, 6, 0, alu3, imm4, tail, 0, 0));
    tbl.push_back(mk(5'd13, 0, 6, 0, alu3, imm4, tail, 0, 0));
    tbl.push_back(mk(5'd18, 0, 7, 0, GRA | ROUT | CONIN, PCOUT | YIN,
                     COUT | ZLOWIN, 0, 0));
    tbl.push_back(mk(5'd18, 1, 7, 0, GRA | ROUT | CONIN, PCOUT | YIN,
                     COUT | ZLOWIN, ZLOWOUT | PCIN, 0));
    tbl.push_back(mk(5'd19, 0, 4, 0, GRA | ROUT | PCIN, 0, 0, 0, 0));
    tbl.push_back(mk(5'd21, 0, 4, 0, GRA | RIN | INPOUT, 0, 0, 0, 0));
    tbl.push_back(mk(5'd22, 0, 4, 0, GRA | ROUT | OUTPIN, 0, 0, 0, 0));
    tbl.push_back(mk(5'd23, 0, 4, 0, GRA | RIN | HIOUT, 0, 0, 0, 0));
    tbl.push_back(mk(5'd24, 0, 4, 0, GRA | RIN | LOOUT, 0, 0, 0, 0));
    tbl.push_back(mk(5'd25, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'd26, 0, 3, 1, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      start(tbl[i].op, tbl[i].con);
      for (int c = 0; c < int'(tbl[i].len); c++) begin
        step();
        chk($sformatf("op%0d con%0d c%0d", tbl[i].op, tbl[i].con, c),
            tbl[i].exp[c]);
      end
      step();
      chk($sformatf("op%0d after", tbl[i].op),
          tbl[i].halts ? 25'd0 : F0);
      if (tbl[i].halts) begin
        step();
        chk("halt hold", 25'd0);
      end
    end

    // Stop raised during add T4, opcode changed: add finishes then HALT.
    start(5'd3, 0);
    step(); step(); step();
    chk("stop T2", F2);
    step();
    chk("stop T3", alu3 | RUN);
    step();
    chk("stop T4", GRC | ROUT | ZLOWIN | RUN);
    stop = 1'b1;
    opcode = 5'd25;
    step();
    chk("stop T5", tail | RUN);
    step();
    chk("stop halt", 25'd0);
    opcode = 5'd0;
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("halt abs%0d", k), 25'd0);
    end

    // Stop is ignored before the last state of nop.
    start(5'd25, 0);
    stop = 1'b1;
    step(); chk("nop stop T0", F0);
    step(); chk("nop stop T1", F1);
    step(); chk("nop stop T2", F2);
    step(); chk("nop stop halt", 25'd0);

    // Clear pulsed during ld T6 aborts within the cycle.
    start(5'd0, 0);
    for (int k = 0; k < 7; k++) step();
    chk("ld T6", READ | MDRIN | RUN);
    #2;
    clear = 1'b0;
    #1;
    chk("clear async", 25'd0);
    step();
    chk("clear held", 25'd0);
    clear = 1'b1;
    step();
    chk("restart T0", F0);
    step();
    chk("restart T1", F1);

    // Sweep every opcode and measure instruction latency.
    for (int op = 0; op < 32; op++) begin
      start(5'(op), 0);
      n = 0;
      done = 0;
      for (int c = 0; c < 12 && !done; c++) begin
        step();
        checks++;
        if ($countones(act & DRV) > 1) begin
          errors++;
          $display("FAIL sweep op%0d bus: drivers %h", op, act & DRV);
        end
        if (c > 0 && (act == F0 || act == 25'd0)) begin
          done = 1;
          n = c;
        end
      end
      checks++;
      if (n != exp_lat(5'(op))) begin
        errors++;
        $display("FAIL sweep op%0d lat: got %0d want %0d",
                 op, n, exp_lat(5'(op)));
      end
      checks++;
      if (act !== ((op == 26) ? 25'd0 : F0)) begin
        errors++;
        $display("FAIL sweep op%0d end: got %h", op, act);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
